// File: rtl/rs_ram8_arbiter.sv
// Two-requester round-robin access controller for a single-port 256x8 RAM with
// post-reset clear sweep, bounded lock holding and read-data return routing.
module rs_ram8_arbiter #(
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter int unsigned MAX_LOCK       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] di0,
    input  logic [7:0] di1,
    input  logic       lock0,
    input  logic       lock1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       rvalid0,
    output logic       rvalid1,
    output logic [7:0] do0,
    output logic [7:0] do1,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_di,
    output logic       ram_we,
    input  logic [7:0] ram_do,
    output logic       busy,
    output logic       state_dbg
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam state_t     RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
    localparam logic [3:0] MAX_LOCK_C  = 4'(MAX_LOCK);

    state_t     state;
    state_t     state_next;
    logic [7:0] clr_addr;
    logic       last;
    logic       last_lock;
    logic [3:0] lock_cnt;
    logic [3:0] lock_cnt_next;
    logic       rd_pend;
    logic       rd_owner;

    logic       grant;
    logic       gsel;
    logic       other_req;

    // Grant selection: lock hold first, then single request, then round-robin tie.
    always_comb begin
        grant = 1'b0;
        gsel  = 1'b0;
        if (rst_n && state == ST_RUN) begin
            if (last_lock && (last ? req1 : req0) && lock_cnt < MAX_LOCK_C) begin
                grant = 1'b1;
                gsel  = last;
            end else if (req0 ^ req1) begin
                grant = 1'b1;
                gsel  = req1;
            end else if (req0 && req1) begin
                grant = 1'b1;
                gsel  = ~last;
            end
        end
    end

    always_comb begin
        other_req     = gsel ? req0 : req1;
        lock_cnt_next = 4'd0;
        if (other_req) begin
            if (gsel == last) begin
                lock_cnt_next = (lock_cnt == 4'hF) ? 4'hF : lock_cnt + 4'd1;
            end else begin
                lock_cnt_next = 4'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        if (state == ST_CLEAR && clr_addr == 8'hFF) begin
            state_next = ST_RUN;
        end
    end

    // RAM port mux; the sweep write is suppressed while reset is asserted.
    always_comb begin
        gnt0     = grant && !gsel;
        gnt1     = grant && gsel;
        ram_we   = 1'b0;
        ram_addr = 8'h00;
        ram_di   = 8'h00;
        if (state == ST_CLEAR) begin
            ram_addr = clr_addr;
            ram_we   = rst_n;
        end else if (grant) begin
            ram_addr = gsel ? addr1 : addr0;
            ram_di   = gsel ? di1 : di0;
            ram_we   = gsel ? we1 : we0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RESET_STATE;
            clr_addr  <= 8'h00;
            last      <= 1'b1;
            last_lock <= 1'b0;
            lock_cnt  <= 4'd0;
            rd_pend   <= 1'b0;
            rd_owner  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_CLEAR) begin
                clr_addr <= clr_addr + 8'd1;
            end
            if (grant) begin
                last      <= gsel;
                last_lock <= gsel ? lock1 : lock0;
                lock_cnt  <= lock_cnt_next;
                rd_pend   <= ~(gsel ? we1 : we0);
                rd_owner  <= gsel;
            end else begin
                last_lock <= 1'b0;
                lock_cnt  <= 4'd0;
                rd_pend   <= 1'b0;
            end
        end
    end

    assign rvalid0   = rd_pend && !rd_owner;
    assign rvalid1   = rd_pend && rd_owner;
    assign do0       = rvalid0 ? ram_do : 8'h00;
    assign do1       = rvalid1 ? ram_do : 8'h00;
    assign busy      = (state == ST_CLEAR);
    assign state_dbg = state;

endmodule

// File: tb/tb_rs_ram8_arbiter.sv
// Directed bench for rs_ram8_arbiter: clear sweep, table-driven arbitration
// vectors against a behavioural RAM, and a mid-operation reset sequence.
module tb_rs_ram8_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0, req1, we0, we1, lock0, lock1;
    logic [7:0] addr0, addr1, di0, di1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] do0, do1;
    logic [7:0] ram_addr, ram_di, ram_do;
    logic       ram_we;
    logic       busy;
    logic       state_dbg;

    int errors = 0;
    int checks = 0;

    rs_ram8_arbiter #(
        .CLEAR_ON_RESET(1'b1),
        .MAX_LOCK      (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .req1     (req1),
        .we0      (we0),
        .we1      (we1),
        .addr0    (addr0),
        .addr1    (addr1),
        .di0      (di0),
        .di1      (di1),
        .lock0    (lock0),
        .lock1    (lock1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .do0      (do0),
        .do1      (do1),
        .ram_addr (ram_addr),
        .ram_di   (ram_di),
        .ram_we   (ram_we),
        .ram_do   (ram_do),
        .busy     (busy),
        .state_dbg(state_dbg)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural RS_RAM8: synchronous write and synchronous read.
    logic [7:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
        ram_do = 8'h00;
    end
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_di;
        ram_do <= mem[ram_addr];
    end

    typedef struct {
        logic       r0, r1, w0, w1, l0, l1;
        logic [7:0] a0, a1, d0, d1;
        logic       g0, g1, v0, v1;
        logic [7:0] o0, o1;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic r0, r1, w0, w1, l0, l1,
                                input logic [7:0] a0, a1, d0, d1,
                                input logic g0, g1, v0, v1,
                                input logic [7:0] o0, o1);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1; v.l0 = l0; v.l1 = l1;
        v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.o0 = o0; v.o1 = o1;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        req0 = v.r0; req1 = v.r1; we0 = v.w0; we1 = v.w1; lock0 = v.l0; lock1 = v.l1;
        addr0 = v.a0; addr1 = v.a1; di0 = v.d0; di1 = v.d1;
    endtask

    initial begin
        int         n;
        logic [7:0] exp_addr, exp_di;
        logic       exp_we;

        // Table: r0 r1 w0 w1 l0 l1 a0 a1 d0 d1 | g0 g1 v0 v1 o0 o1
        vecs[0]  = mk(1,0,1,0,0,0,8'h10,8'h00,8'hA5,8'h00, 1,0,0,0,8'h00,8'h00);
        vecs[1]  = mk(1,0,0,0,0,0,8'h10,8'h00,8'h00,8'h00, 1,0,0,0,8'h00,8'h00);
        vecs[2]  = mk(0,0,0,0,0,0,8'h00,8'h00,8'h00,8'h00, 0,0,1,0,8'hA5,8'h00);
        vecs[3]  = mk(0,1,0,1,0,0,8'h00,8'h20,8'h00,8'h5A, 0,1,0,0,8'h00,8'h00);
        vecs[4]  = mk(1,1,0,0,0,0,8'h10,8'h20,8'h00,8'h00, 1,0,0,0,8'h00,8'h00);
        vecs[5]  = mk(1,1,0,0,0,0,8'h10,8'h20,8'h00,8'h00, 0,1,1,0,8'hA5,8'h00);
        vecs[6]  = mk(1,1,0,0,0,0,8'h10,8'h20,8'h00,8'h00, 1,0,0,1,8'h00,8'h5A);
        vecs[7]  = mk(1,1,0,0,0,0,8'h10,8'h20,8'h00,8'h00, 0,1,1,0,8'hA5,8'h00);
        vecs[8]  = mk(1,1,0,0,0,0,8'h10,8'h20,8'h00,8'h00, 1,0,0,1,8'h00,8'h5A);
        vecs[9]  = mk(1,1,0,0,0,0,8'h10,8'h20,8'h00,8'h00, 0,1,1,0,8'hA5,8'h00);
        vecs[10] = mk(0,0,0,0,0,0,8'h00,8'h00,8'h00,8'h00, 0,0,0,1,8'h00,8'h5A);
        vecs[11] = mk(1,1,0,0,1,0,8'h10,8'h20,8'h00,8'h00, 1,0,0,0,8'h00,8'h00);
        vecs[12] = mk(1,1,0,0,1,0,8'h10,8'h20,8'h00,8'h00, 1,0,1,0,8'hA5,8'h00);
        vecs[13] = mk(1,1,0,0,1,0,8'h10,8'h20,8'h00,8'h00, 1,0,1,0,8'hA5,8'h00);
        vecs[14] = mk(1,1,0,0,1,0,8'h10,8'h20,8'h00,8'h00, 1,0,1,0,8'hA5,8'h00);
        vecs[15] = mk(1,1,0,0,1,0,8'h10,8'h20,8'h00,8'h00, 0,1,1,0,8'hA5,8'h00);
        vecs[16] = mk(1,0,0,0,1,0,8'h10,8'h20,8'h00,8'h00, 1,0,0,1,8'h00,8'h5A);
        vecs[17] = mk(0,0,0,0,0,0,8'h00,8'h00,8'h00,8'h00, 0,0,1,0,8'hA5,8'h00);

        // Reset, with both requesters already asking (they must wait for the sweep).
        rst_n = 1'b0;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        addr0 = 8'h7F; addr1 = 8'h20; di0 = 8'h00; di1 = 8'h00;
        #3;
        check("rst gnt0", gnt0, 1'b0);
        check("rst gnt1", gnt1, 1'b0);
        check("rst rvalid0", rvalid0, 1'b0);
        check("rst rvalid1", rvalid1, 1'b0);
        check("rst do0", do0, 8'h00);
        check("rst ram_we", ram_we, 1'b0);
        check("rst ram_addr", ram_addr, 8'h00);
        check("rst ram_di", ram_di, 8'h00);
        check("rst busy", busy, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Clear sweep: 256 cycles of writes to 0..255, no grants.
        n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            check($sformatf("sweep%0d ram_addr", n), ram_addr, 8'(n));
            check($sformatf("sweep%0d ram_we", n), ram_we, 1'b1);
            if (ram_di !== 8'h00 || gnt0 !== 1'b0 || gnt1 !== 1'b0)
                check($sformatf("sweep%0d di/gnt", n), {ram_di[5:0], gnt0, gnt1}, 8'h00);
            n++;
            @(negedge clk);
        end
        check("sweep length", 8'(n - 200), 8'd56);

        // First RUN cycle: tie goes to requester 0.
        check("run0 gnt0", gnt0, 1'b1);
        check("run0 gnt1", gnt1, 1'b0);
        check("run0 ram_addr", ram_addr, 8'h7F);
        check("run0 ram_we", ram_we, 1'b0);
        @(posedge clk); #1 req0 = 1'b0;
        @(negedge clk);
        check("run1 gnt1", gnt1, 1'b1);
        check("run1 ram_addr", ram_addr, 8'h20);
        check("run1 rvalid0", rvalid0, 1'b1);
        check("run1 do0 cleared", do0, 8'h00);
        check("run1 rvalid1", rvalid1, 1'b0);
        @(posedge clk); #1 req1 = 1'b0;
        @(negedge clk);
        check("run2 gnt1", gnt1, 1'b0);
        check("run2 rvalid1", rvalid1, 1'b1);
        check("run2 do1 cleared", do1, 8'h00);

        // Table-driven arbitration vectors.
        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            drive(vecs[i]);
            @(negedge clk);
            exp_we   = vecs[i].g0 ? vecs[i].w0 : (vecs[i].g1 ? vecs[i].w1 : 1'b0);
            exp_addr = vecs[i].g0 ? vecs[i].a0 : (vecs[i].g1 ? vecs[i].a1 : 8'h00);
            exp_di   = vecs[i].g0 ? vecs[i].d0 : (vecs[i].g1 ? vecs[i].d1 : 8'h00);
            check($sformatf("v%0d gnt0", i), gnt0, vecs[i].g0);
            check($sformatf("v%0d gnt1", i), gnt1, vecs[i].g1);
            check($sformatf("v%0d rvalid0", i), rvalid0, vecs[i].v0);
            check($sformatf("v%0d rvalid1", i), rvalid1, vecs[i].v1);
            check($sformatf("v%0d do0", i), do0, vecs[i].o0);
            check($sformatf("v%0d do1", i), do1, vecs[i].o1);
            check($sformatf("v%0d ram_we", i), ram_we, exp_we);
            check($sformatf("v%0d ram_addr", i), ram_addr, exp_addr);
            check($sformatf("v%0d ram_di", i), ram_di, exp_di);
            check($sformatf("v%0d busy", i), busy, 1'b0);
        end

        // Reset pulse while a read return is in flight.
        @(posedge clk); #1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10; lock0 = 1'b0;
        @(negedge clk);
        check("mid gnt0", gnt0, 1'b1);
        @(posedge clk); #1;
        req0 = 1'b0;
        check("mid rvalid0 before reset", rvalid0, 1'b1);
        check("mid do0 before reset", do0, 8'hA5);
        rst_n = 1'b0;
        #1;
        check("mid rvalid0 dropped", rvalid0, 1'b0);
        check("mid do0 dropped", do0, 8'h00);
        check("mid busy", busy, 1'b1);
        check("mid ram_we low in reset", ram_we, 1'b0);
        check("mid ram_addr", ram_addr, 8'h00);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("resweep busy", busy, 1'b1);
        check("resweep ram_addr0", ram_addr, 8'h00);
        check("resweep ram_we", ram_we, 1'b1);
        @(negedge clk);
        check("resweep ram_addr1", ram_addr, 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
